// File: rtl/freq_mon_pkg.sv
// Shared types and widths for the frequency window monitor.
package freq_mon_pkg;

    localparam int FREQ_W       = 32;
    localparam int AVG_LOG2_DEF = 2;
    localparam int SUM_W        = FREQ_W + AVG_LOG2_DEF;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_OK   = 2'd1,
        ST_LOW  = 2'd2,
        ST_HIGH = 2'd3
    } mon_state_t;

endpackage

// File: rtl/freq_avg_ring.sv
// Moving average over 2^AVG_LOG2 accepted samples, kept as a ring buffer plus running sum.
module freq_avg_ring
    import freq_mon_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              freq_valid,
    output logic [FREQ_W-1:0] avg_freq,
    output logic              avg_valid
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = FREQ_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);

    logic [FREQ_W-1:0]   ring_q [DEPTH];
    logic [FREQ_W-1:0]   ring_d [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [AVG_LOG2:0]   fill_q, fill_d;
    logic [SW-1:0]       sum_q, sum_d, sum_new;
    logic [FREQ_W-1:0]   avg_freq_q, avg_freq_d;
    logic                avg_valid_q, avg_valid_d;
    logic                accept;

    always_comb begin
        accept      = en && freq_valid;
        ring_d      = ring_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        sum_d       = sum_q;
        avg_freq_d  = avg_freq_q;
        avg_valid_d = 1'b0;
        // The evicted slot is always part of sum_q, so the result never underflows.
        sum_new     = sum_q + SW'(freq_in) - SW'(ring_q[wr_ptr_q]);
        if (accept) begin
            ring_d[wr_ptr_q] = freq_in;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            sum_d            = sum_new;
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
            if (fill_d == FILL_FULL) begin
                avg_freq_d  = sum_new[SW-1:AVG_LOG2];
                avg_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            sum_q       <= '0;
            avg_freq_q  <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            ring_q      <= ring_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            sum_q       <= sum_d;
            avg_freq_q  <= avg_freq_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign avg_freq  = avg_freq_q;
    assign avg_valid = avg_valid_q;

endmodule

// File: rtl/freq_window_monitor.sv
// Classifies the averaged frequency against a low/high window with entry debounce,
// exit hysteresis and a sticky alarm. avg_valid is a one-cycle pulse; there is no backpressure.
module freq_window_monitor
    import freq_mon_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int HYST     = 1000,
    parameter int DEBOUNCE = 3
) (
    input  logic                ref_clk,
    input  logic                rst,
    input  logic                en,
    input  logic [FREQ_W-1:0]   freq_in,
    input  logic                freq_valid,
    input  logic [FREQ_W-1:0]   thr_lo,
    input  logic [FREQ_W-1:0]   thr_hi,
    input  logic                clr_alarm,
    output logic [FREQ_W-1:0]   avg_freq,
    output logic                avg_valid,
    output logic [1:0]          mon_state,
    output logic                too_low,
    output logic                too_high,
    output logic                alarm_sticky
);

    localparam logic [3:0]        DEB    = 4'(DEBOUNCE);
    localparam logic [FREQ_W-1:0] HYST_V = FREQ_W'(HYST);

    mon_state_t        state_q, state_d, eval_st;
    logic [3:0]        lo_cnt_q, lo_cnt_d, hi_cnt_q, hi_cnt_d;
    logic              too_low_q, too_low_d, too_high_q, too_high_d;
    logic              alarm_q, alarm_d;
    logic              entering;
    logic [FREQ_W:0]   lo_exit;
    logic [FREQ_W-1:0] hi_exit;

    freq_avg_ring #(.AVG_LOG2(AVG_LOG2)) u_ring (
        .clk        (ref_clk),
        .rst        (rst),
        .en         (en),
        .freq_in    (freq_in),
        .freq_valid (freq_valid),
        .avg_freq   (avg_freq),
        .avg_valid  (avg_valid)
    );

    always_comb begin
        state_d  = state_q;
        lo_cnt_d = lo_cnt_q;
        hi_cnt_d = hi_cnt_q;
        eval_st  = (state_q == ST_FILL) ? ST_OK : state_q;
        lo_exit  = {1'b0, thr_lo} + {1'b0, HYST_V};
        hi_exit  = (thr_hi > HYST_V) ? (thr_hi - HYST_V) : '0;
        if (avg_valid) begin
            state_d = eval_st;
            case (eval_st)
                ST_OK: begin
                    // Low check first so a misconfigured window (thr_lo > thr_hi) reads as low.
                    if (avg_freq < thr_lo) begin
                        lo_cnt_d = lo_cnt_q + 1'b1;
                        hi_cnt_d = '0;
                    end else if (avg_freq > thr_hi) begin
                        hi_cnt_d = hi_cnt_q + 1'b1;
                        lo_cnt_d = '0;
                    end else begin
                        lo_cnt_d = '0;
                        hi_cnt_d = '0;
                    end
                    if (lo_cnt_d >= DEB) begin
                        state_d  = ST_LOW;
                        lo_cnt_d = '0;
                        hi_cnt_d = '0;
                    end else if (hi_cnt_d >= DEB) begin
                        state_d  = ST_HIGH;
                        lo_cnt_d = '0;
                        hi_cnt_d = '0;
                    end
                end
                ST_LOW: begin
                    if ({1'b0, avg_freq} >= lo_exit) state_d = ST_OK;
                end
                ST_HIGH: begin
                    if (avg_freq <= hi_exit) state_d = ST_OK;
                end
                default: state_d = ST_OK;
            endcase
        end
        entering   = (state_d != state_q) && ((state_d == ST_LOW) || (state_d == ST_HIGH));
        alarm_d    = entering ? 1'b1 : (clr_alarm ? 1'b0 : alarm_q);
        too_low_d  = (state_d == ST_LOW);
        too_high_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q    <= ST_FILL;
            lo_cnt_q   <= '0;
            hi_cnt_q   <= '0;
            too_low_q  <= 1'b0;
            too_high_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_cnt_q   <= lo_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            too_low_q  <= too_low_d;
            too_high_q <= too_high_d;
            alarm_q    <= alarm_d;
        end
    end

    assign mon_state    = state_q;
    assign too_low      = too_low_q;
    assign too_high     = too_high_q;
    assign alarm_sticky = alarm_q;

endmodule

// File: tb/tb_freq_window_monitor.sv
// Self-checking bench for freq_window_monitor: vector table plus hand-written corner sequences.
module tb_freq_window_monitor;

    logic        ref_clk = 1'b0;
    logic        rst, en, freq_valid, clr_alarm;
    logic [31:0] freq_in, thr_lo, thr_hi;
    logic [31:0] avg_freq;
    logic        avg_valid, too_low, too_high, alarm_sticky;
    logic [1:0]  mon_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_ring[4];
    int          m_ptr, m_cnt;

    typedef struct {
        bit          do_rst;
        logic [31:0] freq;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [1:0]  st;
        logic        alarm;
    } vec_t;

    vec_t vecs[18];

    always #5 ref_clk = ~ref_clk;

    freq_window_monitor #(.AVG_LOG2(2), .HYST(1000), .DEBOUNCE(3)) dut (
        .ref_clk      (ref_clk),
        .rst          (rst),
        .en           (en),
        .freq_in      (freq_in),
        .freq_valid   (freq_valid),
        .thr_lo       (thr_lo),
        .thr_hi       (thr_hi),
        .clr_alarm    (clr_alarm),
        .avg_freq     (avg_freq),
        .avg_valid    (avg_valid),
        .mon_state    (mon_state),
        .too_low      (too_low),
        .too_high     (too_high),
        .alarm_sticky (alarm_sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_ring[i] = '0;
        m_ptr = 0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_push(input logic [31:0] f);
        logic [33:0] s;
        m_ring[m_ptr] = f;
        m_ptr = (m_ptr + 1) % 4;
        if (m_cnt < 4) m_cnt++;
        if (m_cnt == 4) begin
            s = {2'b00, m_ring[0]} + {2'b00, m_ring[1]} + {2'b00, m_ring[2]} + {2'b00, m_ring[3]};
            exp_q.push_back(s[33:2]);
        end
    endtask

    // Advance to the next falling edge and settle any average the last edge should have produced.
    task automatic tick();
        @(negedge ref_clk);
        if (exp_q.size() > 0) begin
            chk("avg_valid", 32'(avg_valid), 32'd1);
            chk("avg_freq", avg_freq, exp_q.pop_front());
        end else if (avg_valid) begin
            chk("spurious_avg_valid", 32'(avg_valid), 32'd0);
        end
    endtask

    task automatic drive_sample(input logic [31:0] f);
        freq_in    = f;
        freq_valid = 1'b1;
        if (en) model_push(f);
        tick();
        freq_valid = 1'b0;
    endtask

    task automatic check_outputs(input string name, input logic [1:0] st, input logic alarm);
        chk({name, "_state"}, 32'(mon_state), 32'(st));
        chk({name, "_too_low"}, 32'(too_low), 32'(st == 2'd2));
        chk({name, "_too_high"}, 32'(too_high), 32'(st == 2'd3));
        chk({name, "_alarm"}, 32'(alarm_sticky), 32'(alarm));
    endtask

    task automatic step(input string name, input logic [31:0] f, input logic [1:0] st, input logic alarm);
        drive_sample(f);
        tick();
        check_outputs(name, st, alarm);
    endtask

    task automatic do_reset();
        model_clear();
        rst = 1'b1;
        tick();
        check_outputs("reset", 2'd0, 1'b0);
        chk("reset_avg_valid", 32'(avg_valid), 32'd0);
        chk("reset_avg_freq", avg_freq, 32'd0);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input bit r, input logic [31:0] f, input logic [31:0] lo,
                                input logic [31:0] hi, input logic [1:0] st, input logic a);
        vec_t v;
        v.do_rst = r; v.freq = f; v.lo = lo; v.hi = hi; v.st = st; v.alarm = a;
        return v;
    endfunction

    initial begin
        logic [1:0] prev_st;
        int         n_avg;

        rst = 1'b1; en = 1'b1; freq_valid = 1'b0; clr_alarm = 1'b0;
        freq_in = '0; thr_lo = '0; thr_hi = '0;
        model_clear();

        // Fill, low entry with debounce, hysteresis exit.
        vecs[0]  = mk(1, 1000,       0,         20_000_000, 2'd0, 0);
        vecs[1]  = mk(0, 2000,       0,         20_000_000, 2'd0, 0);
        vecs[2]  = mk(0, 3000,       0,         20_000_000, 2'd0, 0);
        vecs[3]  = mk(0, 4000,       0,         20_000_000, 2'd1, 0);
        vecs[4]  = mk(1, 10_000_000, 9_500_000, 10_500_000, 2'd0, 0);
        vecs[5]  = mk(0, 10_000_000, 9_500_000, 10_500_000, 2'd0, 0);
        vecs[6]  = mk(0, 10_000_000, 9_500_000, 10_500_000, 2'd0, 0);
        vecs[7]  = mk(0, 10_000_000, 9_500_000, 10_500_000, 2'd1, 0);
        vecs[8]  = mk(0, 9_000_000,  9_500_000, 10_500_000, 2'd1, 0);
        vecs[9]  = mk(0, 9_000_000,  9_500_000, 10_500_000, 2'd1, 0);
        vecs[10] = mk(0, 9_000_000,  9_500_000, 10_500_000, 2'd1, 0);
        vecs[11] = mk(0, 9_000_000,  9_500_000, 10_500_000, 2'd1, 0);
        vecs[12] = mk(0, 9_000_000,  9_500_000, 10_500_000, 2'd2, 1);
        vecs[13] = mk(0, 9_500_000,  9_500_000, 10_500_000, 2'd2, 1);
        vecs[14] = mk(0, 9_500_000,  9_500_000, 10_500_000, 2'd2, 1);
        vecs[15] = mk(0, 9_500_000,  9_500_000, 10_500_000, 2'd2, 1);
        vecs[16] = mk(0, 9_500_000,  9_500_000, 10_500_000, 2'd2, 1);
        vecs[17] = mk(0, 9_600_000,  9_500_000, 10_500_000, 2'd1, 1);

        tick();
        do_reset();
        prev_st = 2'd0;

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].do_rst) begin
                do_reset();
                prev_st = 2'd0;
            end
            thr_lo = vecs[i].lo;
            thr_hi = vecs[i].hi;
            drive_sample(vecs[i].freq);
            chk($sformatf("vec%0d_early_state", i), 32'(mon_state), 32'(prev_st));
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].st, vecs[i].alarm);
            prev_st = vecs[i].st;
        end

        // Alarm stays until cleared.
        clr_alarm = 1'b1;
        tick();
        clr_alarm = 1'b0;
        check_outputs("clr_after_low", 2'd1, 1'b0);

        // Sticky priority: clear coincides with HIGH entry.
        do_reset();
        thr_lo = 9_500_000;
        thr_hi = 10_500_000;
        step("hi_fill0", 20_000_000, 2'd0, 1'b0);
        step("hi_fill1", 20_000_000, 2'd0, 1'b0);
        step("hi_fill2", 20_000_000, 2'd0, 1'b0);
        step("hi_deb1", 20_000_000, 2'd1, 1'b0);
        step("hi_deb2", 20_000_000, 2'd1, 1'b0);
        drive_sample(20_000_000);
        clr_alarm = 1'b1;
        tick();
        clr_alarm = 1'b0;
        check_outputs("hi_entry_clr", 2'd3, 1'b1);
        clr_alarm = 1'b1;
        tick();
        clr_alarm = 1'b0;
        check_outputs("hi_lone_clr", 2'd3, 1'b0);

        // HIGH exit right at thr_hi - HYST (avg 15_000_000, then exactly 10_499_000).
        step("hi_hold", 0, 2'd3, 1'b0);
        step("hi_exit_edge", 1_996_000, 2'd1, 1'b0);

        // Back-to-back full-scale samples.
        do_reset();
        thr_lo = 0;
        thr_hi = 32'hFFFF_FFFF;
        n_avg = 0;
        for (int i = 0; i < 6; i++) begin
            freq_in    = 32'hFFFF_FFFF;
            freq_valid = 1'b1;
            model_push(32'hFFFF_FFFF);
            tick();
            if (avg_valid) n_avg++;
        end
        freq_valid = 1'b0;
        chk("b2b_avg_count", 32'(n_avg), 32'd3);
        tick();
        check_outputs("b2b_end", 2'd1, 1'b0);

        // en low freezes everything but clr_alarm; reset mid-LOW restarts the fill.
        do_reset();
        thr_lo = 9_500_000;
        thr_hi = 10_500_000;
        step("en_fill0", 1000, 2'd0, 1'b0);
        step("en_fill1", 1000, 2'd0, 1'b0);
        step("en_fill2", 1000, 2'd0, 1'b0);
        step("en_deb1", 1000, 2'd1, 1'b0);
        step("en_deb2", 1000, 2'd1, 1'b0);
        step("en_low", 1000, 2'd2, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_sample(20_000_000 + 32'($urandom_range(0, 1000)));
            chk($sformatf("en0_no_avg%0d", i), 32'(avg_valid), 32'd0);
            tick();
            check_outputs($sformatf("en0_hold%0d", i), 2'd2, 1'b1);
        end
        clr_alarm = 1'b1;
        tick();
        clr_alarm = 1'b0;
        check_outputs("en0_clr", 2'd2, 1'b0);
        en = 1'b1;
        do_reset();
        step("refill0", 10_000_000, 2'd0, 1'b0);
        step("refill1", 10_000_000, 2'd0, 1'b0);
        step("refill2", 10_000_000, 2'd0, 1'b0);
        step("refill3", 10_000_000, 2'd1, 1'b0);

        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/freq_window_monitor.md
Name: freq_window_monitor

Overview:
- Sits directly downstream of the frequency counter, in the ref_clk domain.
- Consumes each new frequency measurement (32-bit Hz value plus a one-cycle update strobe) and forms a moving average over 2^AVG_LOG2 samples.
- Classifies the averaged frequency against a low/high window, with debounce on entry and hysteresis on exit.
- Drives range flags and a sticky alarm for software.

Parameters:
- AVG_LOG2, 2: log2 of averaging depth (DEPTH = 4 samples).
- HYST, 1000: exit hysteresis in Hz.
- DEBOUNCE, 3: consecutive out-of-window averages required to enter an alarm state (range 1..15).

Ports:
- ref_clk  in  1  system clock; same clock as the upstream counter's output register.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; when low, freq_valid is ignored and all state is held.
- freq_in  in  32  measured frequency in Hz.
- freq_valid  in  1  one-cycle pulse; freq_in is valid.
- thr_lo  in  32  lower window limit in Hz; quasi-static.
- thr_hi  in  32  upper window limit in Hz; quasi-static.
- clr_alarm  in  1  one-cycle pulse that clears alarm_sticky.
- avg_freq  out  32  current moving average.
- avg_valid  out  1  one-cycle pulse when avg_freq updates.
- mon_state  out  2  0=FILL, 1=OK, 2=LOW, 3=HIGH.
- too_low  out  1  mon_state==LOW.
- too_high  out  1  mon_state==HIGH.
- alarm_sticky  out  1  set on entry to LOW or HIGH.

Behaviour:
- Reset values:
  - All outputs 0; mon_state=FILL.
  - Ring buffer, running sum, fill count and debounce counters all 0.
- Accepted sample: freq_valid && en in cycle N.
  - Write freq_in to the ring slot at the write pointer; the write pointer wraps modulo DEPTH.
  - sum <= sum + freq_in - evicted_slot.
  - sum width is 32+AVG_LOG2 bits and cannot overflow.
- Averaging latency:
  - Cycle N+1: avg_freq = sum_new >> AVG_LOG2 (truncating).
  - avg_valid pulses only if at least DEPTH samples have been accepted since reset.
  - The fill count saturates at DEPTH.
- Throughput: back-to-back freq_valid on every cycle is supported, with no sample loss.
- Classification happens in cycle N+2, on each avg_valid:
  - FILL -> OK on the first avg_valid, then evaluated as OK in the same step.
  - OK:
    - If avg < thr_lo, increment lo_cnt and clear hi_cnt.
    - Else if avg > thr_hi, increment hi_cnt and clear lo_cnt.
    - Else clear both.
    - When lo_cnt reaches DEBOUNCE, go to LOW; when hi_cnt reaches DEBOUNCE, go to HIGH. Counters clear on transition.
  - LOW -> OK when avg >= thr_lo + HYST. The sum is computed at 33 bits, so there is no wrap.
  - HIGH -> OK when avg <= thr_hi - HYST. The difference saturates at 0.
  - There is no direct LOW<->HIGH transition; the block must pass through OK and re-debounce.
- Misconfigured window (thr_lo > thr_hi): the low check has priority.
- too_low and too_high are registered decodes of mon_state, updating in the same cycle as mon_state.
- alarm_sticky:
  - Set in the cycle mon_state enters LOW or HIGH.
  - Cleared by clr_alarm.
  - Set wins over a simultaneous clear.
- en low: samples dropped, clr_alarm still honoured, everything else frozen.
- rst mid-operation: immediate return to reset values; a new fill of DEPTH samples is required.
- Threshold changes take effect at the next avg_valid.

Decomposition:
- Package freq_mon_pkg:
  - mon_state_t enum (FILL, OK, LOW, HIGH).
  - SUM_W = 32+AVG_LOG2.
  - FREQ_W = 32.
- Sub-module freq_avg_ring contains the ring buffer, write pointer, running sum, fill count and the avg_freq/avg_valid registers.
- The top level contains the classification FSM, the debounce counters and the sticky logic.

Test Plan (AVG_LOG2=2, HYST=1000, DEBOUNCE=3):
- Fill: thr_lo=0, thr_hi=20_000_000; samples 1000, 2000, 3000, 4000.
  - No avg_valid for the first three samples.
  - avg_valid one cycle after the 4th sample, with avg_freq=2500.
  - mon_state=OK one cycle later.
- Low entry: thr_lo=9_500_000, thr_hi=10_500_000.
  - Four samples of 10_000_000 give OK.
  - Then samples of 9_000_000 give averages 9_750_000, 9_500_000, 9_250_000, 9_000_000, 9_000_000.
  - Required: LOW, too_low=1 and alarm_sticky=1 two cycles after the 5th low sample, not earlier.
- Hysteresis exit: from LOW, four samples of 9_500_000 keep mon_state=LOW (avg 9_500_000 < 9_501_000).
  - Next sample 9_600_000 gives avg 9_525_000, then OK and too_low=0.
  - alarm_sticky stays 1 until clr_alarm.
- Sticky priority: clr_alarm pulsed in the same cycle as HIGH entry.
  - Required: alarm_sticky=1.
  - A later lone clr_alarm gives 0.
- Width/back-to-back: freq_valid on four consecutive cycles with freq_in=0xFFFF_FFFF.
  - Required: avg_freq=0xFFFF_FFFF with no wrap; each sample produces an avg_valid pulse once filled.
- en/reset: with en=0, freq_valid pulses produce no avg_valid and no state change.
  - rst asserted while in LOW gives all outputs 0 and mon_state=FILL on the next edge.
  - Four new samples are required before the next avg_valid.
